// File: rtl/frame_pkg.sv
// Shared definitions for the OLED frame synchronisation logic: panel geometry,
// default animation divider and the update-handshake state encoding.
package frame_pkg;

  localparam int OLED_WIDTH       = 96;
  localparam int OLED_HEIGHT      = 64;
  localparam int DEFAULT_ANIM_DIV = 4;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } sync_state_e;

endpackage

// File: rtl/rise_detect.sv
// Registered rising-edge detector. The delay flop resets to 1, so a level that is
// already high when reset is released does not produce a pulse.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic sig_in,
  output logic rise,
  output logic pulse
);

  logic sig_d_q;
  logic sig_d_d;
  logic pulse_q;
  logic pulse_d;

  always_comb begin
    sig_d_d = sig_in;
    rise    = sig_in & ~sig_d_q;
    pulse_d = rise;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sig_d_q <= 1'b1;
      pulse_q <= 1'b0;
    end else begin
      sig_d_q <= sig_d_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/frame_sync_ctrl.sv
// Turns the stretched OLED vsync level into frame pulses, a frame counter, a divided
// animation tick and a once-per-frame update handshake with overrun detection.
module frame_sync_ctrl
  import frame_pkg::*;
#(
  parameter int unsigned ANIM_DIV    = DEFAULT_ANIM_DIV,
  parameter int unsigned FRAME_CNT_W = 16,
  parameter int unsigned OVR_CNT_W   = 8
) (
  input  logic                   clock_100mhz,
  input  logic                   reset,
  input  logic                   clock_vsync,
  input  logic                   update_done,
  input  logic                   clear_overrun,
  output logic                   frame_start,
  output logic                   anim_tick,
  output logic                   update_req,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output logic                   overrun,
  output logic [OVR_CNT_W-1:0]   overrun_count
);

  localparam logic [7:0] ANIM_LAST = 8'(ANIM_DIV - 1);

  logic                   rise;
  logic [FRAME_CNT_W-1:0] frame_count_q, frame_count_d;
  logic [7:0]             anim_cnt_q, anim_cnt_d;
  logic                   anim_tick_q, anim_tick_d;
  sync_state_e            state_q, state_d;
  logic                   overrun_q, overrun_d;
  logic [OVR_CNT_W-1:0]   overrun_count_q, overrun_count_d;
  logic                   ovr_event;

  rise_detect u_rise_detect (
    .clk    (clock_100mhz),
    .reset  (reset),
    .sig_in (clock_vsync),
    .rise   (rise),
    .pulse  (frame_start)
  );

  // Counters update off the raw edge so their new values line up with frame_start.
  always_comb begin
    frame_count_d = frame_count_q;
    anim_cnt_d    = anim_cnt_q;
    anim_tick_d   = 1'b0;
    if (rise) begin
      frame_count_d = frame_count_q + FRAME_CNT_W'(1);
      if (anim_cnt_q == ANIM_LAST) begin
        anim_cnt_d  = '0;
        anim_tick_d = 1'b1;
      end else begin
        anim_cnt_d = anim_cnt_q + 8'd1;
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    overrun_d       = overrun_q;
    overrun_count_d = overrun_count_q;
    ovr_event       = 1'b0;
    case (state_q)
      IDLE: begin
        if (frame_start) state_d = REQ;
      end
      REQ: begin
        if (frame_start && !update_done) ovr_event = 1'b1;
        else if (!frame_start && update_done) state_d = IDLE;
      end
    endcase
    // Clearing first lets a coincident overrun land on a zeroed count.
    if (clear_overrun) begin
      overrun_d       = 1'b0;
      overrun_count_d = '0;
    end
    if (ovr_event) begin
      overrun_d = 1'b1;
      if (overrun_count_d != '1) overrun_count_d = overrun_count_d + OVR_CNT_W'(1);
    end
  end

  always_ff @(posedge clock_100mhz) begin
    if (reset) begin
      frame_count_q   <= '0;
      anim_cnt_q      <= '0;
      anim_tick_q     <= 1'b0;
      state_q         <= IDLE;
      overrun_q       <= 1'b0;
      overrun_count_q <= '0;
    end else begin
      frame_count_q   <= frame_count_d;
      anim_cnt_q      <= anim_cnt_d;
      anim_tick_q     <= anim_tick_d;
      state_q         <= state_d;
      overrun_q       <= overrun_d;
      overrun_count_q <= overrun_count_d;
    end
  end

  assign anim_tick     = anim_tick_q;
  assign update_req    = (state_q == REQ);
  assign frame_count   = frame_count_q;
  assign overrun       = overrun_q;
  assign overrun_count = overrun_count_q;

endmodule
